// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter
// Shares the single-port data memory between the CPU datapath and a host port.
// Optional: define ARB_STATS_EN to add host_grants / forced_grants counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       host_grants,
  output logic [15:0]       forced_grants,
`endif
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_CPU      = 2'd0,
    HOST_ISSUE   = 2'd1,
    HOST_CAPTURE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                host_ack_q, host_ack_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                cpu_busy;
  logic                wait_at_max;

  assign cpu_busy    = cpu_mem_read | cpu_mem_write;
  assign wait_at_max = (wait_cnt_q == MAX_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= OWN_CPU;
      wait_cnt_q   <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    mem_read     = cpu_mem_read;
    mem_write    = cpu_mem_write;
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    cpu_stall    = 1'b0;

    case (state_q)
      OWN_CPU: begin
        // host_ack_q blocks a re-grant of the request being acknowledged
        if (host_req && !host_ack_q && (!cpu_busy || wait_at_max)) begin
          state_d = HOST_ISSUE;
        end else if (host_req && cpu_busy) begin
          if (!wait_at_max) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else if (!host_req) begin
          wait_cnt_d = '0;
        end
      end
      HOST_ISSUE: begin
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
        mem_write  = host_we;
        mem_read   = !host_we;
        cpu_stall  = 1'b1;
        wait_cnt_d = '0;
        if (host_we) begin
          state_d    = OWN_CPU;
          host_ack_d = 1'b1;
        end else begin
          state_d = HOST_CAPTURE;
        end
      end
      HOST_CAPTURE: begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        cpu_stall    = 1'b1;
        host_rdata_d = mem_rdata;
        host_ack_d   = 1'b1;
        state_d      = OWN_CPU;
      end
      default: begin
        state_d = OWN_CPU;
      end
    endcase
  end

  assign cpu_rdata  = mem_rdata;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] host_grants_q, host_grants_d;
  logic [15:0] forced_grants_q, forced_grants_d;
  logic        forced_grant;

  assign forced_grant = (state_q == OWN_CPU) && host_req && !host_ack_q && wait_at_max;

  always_comb begin
    host_grants_d   = host_grants_q;
    forced_grants_d = forced_grants_q;
    if (host_ack_q && (host_grants_q != 16'hFFFF)) begin
      host_grants_d = host_grants_q + 16'd1;
    end
    if (forced_grant && (forced_grants_q != 16'hFFFF)) begin
      forced_grants_d = forced_grants_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_grants_q   <= '0;
      forced_grants_q <= '0;
    end else begin
      host_grants_q   <= host_grants_d;
      forced_grants_q <= forced_grants_d;
    end
  end

  assign host_grants   = host_grants_q;
  assign forced_grants = forced_grants_q;
`endif

endmodule

`default_nettype wire
